// File: rtl/fir_coeff_streamer_if.sv
// Host/filter bundle for the FIR coefficient streamer: shadow-bank write port,
// start request, and the serial coefficient valid/ready stream with status flags.
interface fir_coeff_streamer_if #(
    parameter int CW = 16,
    parameter int AW = 5
);
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [CW-1:0] wr_data;
    logic          start;
    logic          coeff_ready;
    logic [CW-1:0] coeff_out;
    logic          coeff_valid;
    logic          frame_last;
    logic          busy;
    logic          done;
    logic          start_ovr;

    // The host and filter side of the bundle
    modport master (
        output wr_en, wr_addr, wr_data, start, coeff_ready,
        input  coeff_out, coeff_valid, frame_last, busy, done, start_ovr
    );

    // The streamer side of the bundle
    modport slave (
        input  wr_en, wr_addr, wr_data, start, coeff_ready,
        output coeff_out, coeff_valid, frame_last, busy, done, start_ovr
    );
endinterface

// File: rtl/fir_coeff_streamer.sv
// Double-buffered coefficient writer: the host fills a shadow bank, and a start
// request snapshots it and streams tap TAPS-1 down to tap 0 over valid/ready.
module fir_coeff_streamer #(
    parameter int TAPS = 32,
    parameter int CW   = 16,
    parameter int AW   = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    fir_coeff_streamer_if.slave   bus
);
    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] STREAM = 1'b1;

    logic [0:0]    state;
    logic [AW-1:0] cnt;
    logic [CW-1:0] shadow [TAPS];
    logic [CW-1:0] active [TAPS];
    logic          done_q;
    logic          ovr_q;

    // Shadow writes land after the snapshot copy, so a same-cycle start keeps the old value
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < TAPS; i++) begin
                shadow[i] <= '0;
            end
        end else if (bus.wr_en) begin
            shadow[bus.wr_addr] <= bus.wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= AW'(TAPS - 1);
            done_q <= 1'b0;
            ovr_q  <= 1'b0;
            for (int i = 0; i < TAPS; i++) begin
                active[i] <= '0;
            end
        end else begin
            done_q <= 1'b0;
            if (state == IDLE) begin
                if (bus.start) begin
                    active <= shadow;
                    cnt    <= AW'(TAPS - 1);
                    state  <= STREAM;
                end
            end else begin
                if (bus.start) begin
                    ovr_q <= 1'b1;
                end
                // cnt stops at tap 0 and is only reloaded by the next start
                if (bus.coeff_ready) begin
                    if (cnt == '0) begin
                        state  <= IDLE;
                        done_q <= 1'b1;
                    end else begin
                        cnt <= cnt - AW'(1);
                    end
                end
            end
        end
    end

    // active[cnt] after a frame is still the last word sent, so coeff_out holds in IDLE
    assign bus.coeff_out   = active[cnt];
    assign bus.coeff_valid = (state == STREAM);
    assign bus.busy        = (state == STREAM);
    assign bus.frame_last  = (state == STREAM) && (cnt == '0);
    assign bus.done        = done_q;
    assign bus.start_ovr   = ovr_q;
endmodule

// File: tb/tb_fir_coeff_streamer.sv
// Directed bench for fir_coeff_streamer: table-driven full frames (with a stall),
// then hand sequences for overlap writes, start overrun, same-cycle writes and reset.
module tb_fir_coeff_streamer;
    logic clk;
    logic rst_n;
    int   errors;
    int   checks;
    logic [15:0] model_out;

    typedef struct {
        logic        start;
        logic        ready;
        logic [15:0] exp_out;
        logic        exp_valid;
        logic        exp_last;
        logic        exp_busy;
        logic        exp_done;
    } vec_t;

    vec_t vecs[$];

    fir_coeff_streamer_if #(.CW(16), .AW(5)) bus ();

    fir_coeff_streamer #(.TAPS(32), .CW(16), .AW(5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic add_vec(input logic st, input logic rdy, input logic [15:0] o,
                           input logic v, input logic l, input logic b, input logic d);
        vec_t t;
        t.start = st; t.ready = rdy; t.exp_out = o;
        t.exp_valid = v; t.exp_last = l; t.exp_busy = b; t.exp_done = d;
        vecs.push_back(t);
    endtask

    // Shadow holds tap k = k+1, so words run 32..1; stall_word is the 1-based word to hold
    task automatic add_frame(input int stall_word, input int stall_len);
        int   e;
        int   w;
        int   stall;
        logic rdy;
        add_vec(1'b1, 1'b1, model_out, 1'b0, 1'b0, 1'b0, 1'b0);
        e = 32; w = 1; stall = 0;
        while (e >= 1) begin
            rdy = !(w == stall_word && stall < stall_len);
            add_vec(1'b0, rdy, 16'(e), 1'b1, (e == 1), 1'b1, 1'b0);
            if (rdy) begin
                e--;
                w++;
            end else begin
                stall++;
            end
        end
        model_out = 16'd1;
        add_vec(1'b0, 1'b1, 16'd1, 1'b0, 1'b0, 1'b0, 1'b1);
        add_vec(1'b0, 1'b1, 16'd1, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic apply_stimulus(input vec_t t, input int idx);
        check_output($sformatf("vec%0d out", idx),   bus.coeff_out,   t.exp_out);
        check_output($sformatf("vec%0d valid", idx), bus.coeff_valid, t.exp_valid);
        check_output($sformatf("vec%0d last", idx),  bus.frame_last,  t.exp_last);
        check_output($sformatf("vec%0d busy", idx),  bus.busy,        t.exp_busy);
        check_output($sformatf("vec%0d done", idx),  bus.done,        t.exp_done);
        bus.start       = t.start;
        bus.coeff_ready = t.ready;
        @(negedge clk);
    endtask

    task automatic write_coeff(input logic [4:0] a, input logic [15:0] d);
        bus.wr_en = 1'b1; bus.wr_addr = a; bus.wr_data = d;
        @(negedge clk);
        bus.wr_en = 1'b0;
    endtask

    // Called at a negedge; ends at the negedge of the done cycle so a back-to-back call
    // issues its start while done is high
    task automatic run_frame(input logic [15:0] first, input bit zero_set, input int wr_cycle,
                             input logic [15:0] wr_val, input int ovr_cycle, input string tag);
        logic [15:0] exp;
        bus.start = 1'b1; bus.coeff_ready = 1'b1;
        if (wr_cycle == 0) begin
            bus.wr_en = 1'b1; bus.wr_addr = 5'd31; bus.wr_data = wr_val;
        end
        @(negedge clk);
        bus.start = 1'b0; bus.wr_en = 1'b0;
        for (int j = 0; j < 32; j++) begin
            exp = (j == 0) ? first : (zero_set ? 16'd0 : 16'(32 - j));
            check_output($sformatf("%s w%0d out", tag, j),   bus.coeff_out,   exp);
            check_output($sformatf("%s w%0d valid", tag, j), bus.coeff_valid, 1'b1);
            check_output($sformatf("%s w%0d last", tag, j),  bus.frame_last,  (j == 31));
            if (j + 1 == wr_cycle) begin
                bus.wr_en = 1'b1; bus.wr_addr = 5'd31; bus.wr_data = wr_val;
            end
            if (j + 1 == ovr_cycle) bus.start = 1'b1;
            @(negedge clk);
            bus.start = 1'b0; bus.wr_en = 1'b0;
        end
        check_output({tag, " done"},  bus.done,        1'b1);
        check_output({tag, " valid"}, bus.coeff_valid, 1'b0);
        check_output({tag, " busy"},  bus.busy,        1'b0);
    endtask

    initial begin
        errors = 0; checks = 0; model_out = 16'd0;
        rst_n = 1'b0;
        bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
        bus.start = 1'b0; bus.coeff_ready = 1'b0;

        add_frame(0, 0);
        add_frame(3, 5);

        #12;
        check_output("rst out",   bus.coeff_out,   16'd0);
        check_output("rst valid", bus.coeff_valid, 1'b0);
        check_output("rst last",  bus.frame_last,  1'b0);
        check_output("rst busy",  bus.busy,        1'b0);
        check_output("rst done",  bus.done,        1'b0);
        check_output("rst ovr",   bus.start_ovr,   1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 32; i++) write_coeff(5'(i), 16'(i + 1));

        // Plain frame then a frame stalled on its third word
        for (int i = 0; i < vecs.size(); i++) apply_stimulus(vecs[i], i);
        check_output("t2 ovr", bus.start_ovr, 1'b0);

        // Shadow rewrite mid-stream only affects the next frame
        run_frame(16'd32, 1'b0, 5, 16'h8000, -1, "t3a");
        run_frame(16'h8000, 1'b0, -1, 16'd0, -1, "t3b");
        @(negedge clk);
        write_coeff(5'd31, 16'd32);
        check_output("t4 ovr pre", bus.start_ovr, 1'b0);

        // Start while busy is dropped but flagged
        run_frame(16'd32, 1'b0, -1, 16'd0, 10, "t4a");
        check_output("t4 ovr", bus.start_ovr, 1'b1);
        @(negedge clk);
        check_output("t4 no frame valid", bus.coeff_valid, 1'b0);
        check_output("t4 no frame busy",  bus.busy,        1'b0);
        check_output("t4 no frame done",  bus.done,        1'b0);
        run_frame(16'd32, 1'b0, -1, 16'd0, -1, "t4b");
        check_output("t4 ovr sticky", bus.start_ovr, 1'b1);
        @(negedge clk);

        // Write in the start cycle misses the snapshot
        run_frame(16'd32, 1'b0, 0, 16'd7, -1, "t5a");
        run_frame(16'd7, 1'b0, -1, 16'd0, -1, "t5b");
        @(negedge clk);

        // Asynchronous reset between edges abandons the frame
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        check_output("t6 valid pre", bus.coeff_valid, 1'b1);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_output("t6 rst valid", bus.coeff_valid, 1'b0);
        check_output("t6 rst busy",  bus.busy,        1'b0);
        check_output("t6 rst out",   bus.coeff_out,   16'd0);
        check_output("t6 rst ovr",   bus.start_ovr,   1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check_output($sformatf("t6 idle%0d done", i),  bus.done,        1'b0);
            check_output($sformatf("t6 idle%0d valid", i), bus.coeff_valid, 1'b0);
            @(negedge clk);
        end
        run_frame(16'd0, 1'b1, -1, 16'd0, -1, "t6z");
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/fir_coeff_streamer.md
Name: fir_coeff_streamer

Overview:
- Host-side writer for the adaptive FIR's serial coefficient port. The filter shifts one 16-bit coefficient per cycle into its tap line.
- The host loads a full coefficient set into a shadow bank by address. A start pulse snapshots the set into an active bank, and the block streams it out serially with a valid/ready handshake and a frame marker.
- Double buffering lets the host prepare the next set while the current one streams.

Parameters:
TAPS, 32, number of coefficients per frame (power of two, >=2)
CW, 16, coefficient width (signed two's complement)
AW, 5, address width, equal to log2(TAPS)

Ports:
clk  input  1  single clock; all logic on rising edge
rst_n  input  1  reset, asynchronous and active-low
wr_en  input  1  shadow-bank write strobe
wr_addr  input  AW  shadow-bank tap index
wr_data  input  CW  coefficient value for wr_addr
start  input  1  request to snapshot the shadow bank and stream a frame
coeff_ready  input  1  downstream accepts coeff_out this cycle
coeff_out  output  CW  current coefficient
coeff_valid  output  1  coeff_out is valid
frame_last  output  1  final coefficient of the frame (tap 0)
busy  output  1  high while in STREAM
done  output  1  one-cycle pulse after the last transfer
start_ovr  output  1  sticky flag: start seen while busy

Behaviour:
Reset:
- rst_n low asynchronously forces state=IDLE and cnt=TAPS-1.
- Shadow and active banks are cleared to 0.
- coeff_out=0, coeff_valid=0, frame_last=0, busy=0, done=0, start_ovr=0.
- Reset mid-stream abandons the frame; no done pulse is issued.

Shadow writes:
- wr_en=1 writes wr_data to shadow[wr_addr] at the edge.
- Writes are accepted in any state and never disturb the active bank.

State machine (IDLE, STREAM):
- IDLE, start=1 at edge: active<=shadow (all TAPS entries), cnt<=TAPS-1, state<=STREAM.
- A wr_en in the same cycle as start updates shadow after the copy. The snapshot holds the old value.
- STREAM: coeff_valid=1, busy=1, coeff_out=active[cnt] (mux from registers; no added latency), frame_last=(cnt==0).
- A transfer occurs on an edge with coeff_valid & coeff_ready.
  - cnt>0: cnt decrements by 1.
  - cnt==0: state<=IDLE and done<=1 for exactly the next cycle.
- coeff_ready=0 holds coeff_out, cnt and frame_last stable. Stalls have no limit.

Latency:
- First word is valid on the cycle after the start edge.
- With coeff_ready held high, a frame takes exactly TAPS cycles of coeff_valid, and done is high on cycle TAPS+1 after start.

Order:
- Tap TAPS-1 is sent first and tap 0 last. After TAPS shifts, the filter's tap i holds shadow[i] as snapshotted.

Start handling:
- start while busy (including the cycle of the final transfer) is ignored and sets start_ovr=1.
- start_ovr clears only on reset.
- start in the cycle done is high is legal and begins a new frame.

Arithmetic:
- No arithmetic on data. Values pass bit-exact, sign preserved.
- cnt never wraps below 0; it is reloaded only on start.

Outputs in IDLE:
- coeff_valid=0, frame_last=0, busy=0.
- coeff_out holds its last driven value; downstream must qualify it with coeff_valid.

Test Plan:
1. Reset, write shadow[i]=i+1 for i=0..31, pulse start, coeff_ready=1:
   - coeff_out reads 32,31,...,1 on 32 consecutive cycles.
   - frame_last is high only with value 1.
   - done pulses on cycle 33; busy is low afterwards.
2. Same load, coeff_ready low for 5 cycles after the 3rd word:
   - coeff_out holds 30 for all stall cycles, then resumes 29...1.
   - 32 transfers total, no duplicates.
3. Mid-stream, write shadow[31]=16'h8000, then start again after done:
   - The first frame is unaffected.
   - The second frame's first word is 16'h8000 (signed -32768 preserved).
4. start pulsed on the 10th stream cycle:
   - The frame completes unchanged and start_ovr=1.
   - No second frame begins; start_ovr survives the next frame.
5. Same-cycle start and wr_en(addr=31, data=7) with shadow[31]=32:
   - First streamed word is 32.
   - The following frame's first word is 7.
6. rst_n low asynchronously mid-stream (between edges):
   - coeff_valid and busy drop immediately; no done pulse.
   - After release, start streams all zeros.
